// File: rtl/demux1x8_deser_pkg.sv
// Shared constants and state enumeration for the 1:8 serial-to-parallel deserializer.
package demux1x8_deser_pkg;

  localparam int unsigned NBITS = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/demux1x8_slot.sv
// Registered 1:8 write decoder: owns the shadow frame and writes i_bit into slot i_sel.
module demux1x8_slot #(
  parameter int unsigned NBITS = demux1x8_deser_pkg::NBITS,
  parameter int unsigned SEL_W = demux1x8_deser_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_bit,
  output logic [NBITS-1:0] o_shadow,
  output logic [NBITS-1:0] o_shadow_next
);

  logic [NBITS-1:0] r_shadow;
  logic [NBITS-1:0] w_next;

  // w_next exposes the frame including the bit being written this cycle,
  // so the top can load a completed frame without waiting an extra edge.
  always_comb begin
    w_next        = r_shadow;
    w_next[i_sel] = i_bit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (i_clr) begin
      r_shadow <= '0;
    end else if (i_en) begin
      r_shadow <= w_next;
    end
  end

  assign o_shadow      = r_shadow;
  assign o_shadow_next = w_next;

endmodule

// File: rtl/demux1x8_deser.sv
// 1:8 deserializer: collects LSB-first serial bits into a frame and hands it off
// through a valid/ready output register, stalling input while a frame is parked.
module demux1x8_deser #(
  parameter int unsigned NBITS = demux1x8_deser_pkg::NBITS,
  parameter int unsigned SEL_W = demux1x8_deser_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             clr,
  output logic [SEL_W-1:0] s,
  output logic [NBITS-1:0] i,
  output logic             out_valid,
  input  logic             out_ready
);

  import demux1x8_deser_pkg::*;

  state_t           r_state;
  state_t           w_state_nx;
  logic [SEL_W-1:0] r_s;
  logic [SEL_W-1:0] w_s_nx;
  logic [NBITS-1:0] r_i;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_last;
  logic             w_free;
  logic             w_load_direct;
  logic             w_load_full;
  logic             w_load;
  logic [NBITS-1:0] w_load_data;
  logic [NBITS-1:0] w_shadow;
  logic [NBITS-1:0] w_shadow_next;

  assign bit_ready     = (r_state != FULL);
  assign w_accept      = bit_valid & bit_ready & ~clr;
  assign w_last        = w_accept & (r_s == SEL_W'(NBITS - 1));
  assign w_free        = ~r_out_valid | out_ready;
  assign w_load_direct = w_last & w_free;
  assign w_load_full   = (r_state == FULL) & w_free & ~clr;
  assign w_load        = w_load_direct | w_load_full;
  assign w_load_data   = w_load_full ? w_shadow : w_shadow_next;

  demux1x8_slot #(
    .NBITS (NBITS),
    .SEL_W (SEL_W)
  ) u_slot (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clr         (clr),
    .i_en          (w_accept),
    .i_sel         (r_s),
    .i_bit         (bit_in),
    .o_shadow      (w_shadow),
    .o_shadow_next (w_shadow_next)
  );

  always_comb begin
    w_state_nx = r_state;
    w_s_nx     = r_s;
    if (clr) begin
      w_state_nx = IDLE;
      w_s_nx     = '0;
    end else begin
      case (r_state)
        IDLE, COLLECT: begin
          if (w_accept) begin
            w_s_nx = r_s + SEL_W'(1);
            if (w_last) begin
              w_state_nx = w_free ? IDLE : FULL;
            end else begin
              w_state_nx = COLLECT;
            end
          end
        end
        FULL: begin
          if (w_free) begin
            w_state_nx = IDLE;
          end
        end
        default: begin
          w_state_nx = IDLE;
          w_s_nx     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_s         <= '0;
      r_i         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_s     <= w_s_nx;
      // A load in the handshake cycle keeps out_valid high with the new frame.
      if (w_load) begin
        r_i         <= w_load_data;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign s         = r_s;
  assign i         = r_i;
  assign out_valid = r_out_valid;

endmodule
